csr_spmv_engine: RTL

CSR_SPMV_ENGINE -- requirements
Module: csr_spmv_engine

---
 rtl/csr_pkg.sv | 26 ++
 rtl/sdp_ram.sv | 24 ++
 rtl/csr_spmv_engine.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// Shared encodings for the CSR sparse matrix-vector engine: load targets,
// controller states and RAM timing.
package csr_pkg;

  typedef enum logic [1:0] {
    SEL_VAL = 2'd0,
    SEL_COL = 2'd1,
    SEL_PTR = 2'd2,
    SEL_X   = 2'd3
  } load_sel_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PTR_RD,
    S_PTR_WAIT,
    S_MAC,
    S_MAC_TAIL,
    S_EMIT,
    S_FINISH
  } state_e;

  localparam int RAM_RD_LAT = 1;
  // Cycles after the last MAC issue until its product lands in the accumulator.
  localparam int TAIL_CYC   = 2 * RAM_RD_LAT;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module sdp_ram #(
  parameter int W  = 32,
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem [2**AW];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/csr_spmv_engine.sv
// y = A*x over a CSR matrix held in four on-chip RAMs. Rows are processed one
// at a time through a 3-stage val/col -> x -> MAC pipeline at one nnz per cycle.
module csr_spmv_engine
  import csr_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14,
  parameter int ROW_W  = 10,
  parameter int ACC_W  = 64
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    load_valid_i,
  output logic                    load_ready_o,
  input  logic [1:0]              load_sel_i,
  input  logic [DATA_W-1:0]       load_data_i,
  input  logic                    load_clr_i,
  input  logic                    start_i,
  input  logic [ROW_W-1:0]        num_rows_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    y_valid_o,
  input  logic                    y_ready_i,
  output logic signed [ACC_W-1:0] y_data_o,
  output logic [ROW_W-1:0]        y_row_o,
  output logic                    err_o
);

  localparam logic [DATA_W-1:0] PTR_LIM = DATA_W'(2**ADDR_W);
  localparam logic [DATA_W-1:0] COL_LIM = DATA_W'(2**ROW_W - 1);

  // ---------------- load path ----------------
  logic load_fire, idle_clr;
  logic we_val, we_col, we_ptr, we_x;
  logic [ADDR_W-1:0] wp_val_q, wp_col_q, wa_val, wa_col, wp_val_d, wp_col_d;
  logic [ROW_W-1:0]  wp_ptr_q, wp_x_q, wa_ptr, wa_x, wp_ptr_d, wp_x_d;
  logic busy_q;

  assign load_ready_o = ~busy_q;
  assign load_fire    = load_valid_i & load_ready_o;
  assign idle_clr     = load_clr_i & load_ready_o;
  assign we_val       = load_fire && (load_sel_i == SEL_VAL);
  assign we_col       = load_fire && (load_sel_i == SEL_COL);
  assign we_ptr       = load_fire && (load_sel_i == SEL_PTR);
  assign we_x         = load_fire && (load_sel_i == SEL_X);

  // A word arriving with a clear lands at address 0 of its target.
  always_comb begin
    wa_val   = idle_clr ? '0 : wp_val_q;
    wa_col   = idle_clr ? '0 : wp_col_q;
    wa_ptr   = idle_clr ? '0 : wp_ptr_q;
    wa_x     = idle_clr ? '0 : wp_x_q;
    wp_val_d = wa_val + ADDR_W'(we_val);
    wp_col_d = wa_col + ADDR_W'(we_col);
    wp_ptr_d = wa_ptr + ROW_W'(we_ptr);
    wp_x_d   = wa_x   + ROW_W'(we_x);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wp_val_q <= '0;
      wp_col_q <= '0;
      wp_ptr_q <= '0;
      wp_x_q   <= '0;
    end else begin
      wp_val_q <= wp_val_d;
      wp_col_q <= wp_col_d;
      wp_ptr_q <= wp_ptr_d;
      wp_x_q   <= wp_x_d;
    end
  end

  // ---------------- storage ----------------
  state_e                   state_q;
  logic [ROW_W-1:0]         row_q, nrows_q;
  logic                     ptr_ph_q;
  logic [DATA_W-1:0]        ptr_lo_q, ptr_hi_q, nz_q;
  logic [DATA_W-1:0]        val_rd, col_rd, ptr_rd, x_rd;

  sdp_ram #(.W(DATA_W), .AW(ADDR_W)) u_val_ram (
    .clk_i, .we_i(we_val), .waddr_i(wa_val), .wdata_i(load_data_i),
    .raddr_i(nz_q[ADDR_W-1:0]), .rdata_o(val_rd));

  sdp_ram #(.W(DATA_W), .AW(ADDR_W)) u_col_ram (
    .clk_i, .we_i(we_col), .waddr_i(wa_col), .wdata_i(load_data_i),
    .raddr_i(nz_q[ADDR_W-1:0]), .rdata_o(col_rd));

  sdp_ram #(.W(DATA_W), .AW(ROW_W)) u_ptr_ram (
    .clk_i, .we_i(we_ptr), .waddr_i(wa_ptr), .wdata_i(load_data_i),
    .raddr_i(row_q + ROW_W'(ptr_ph_q)), .rdata_o(ptr_rd));

  // x is addressed straight from the column RAM output (stage 2).
  sdp_ram #(.W(DATA_W), .AW(ROW_W)) u_x_ram (
    .clk_i, .we_i(we_x), .waddr_i(wa_x), .wdata_i(load_data_i),
    .raddr_i(col_rd[ROW_W-1:0]), .rdata_o(x_rd));

  // ---------------- MAC pipeline ----------------
  logic [2:1]                vld_pipe_q;
  logic [DATA_W-1:0]         val_s2_q;
  logic                      bad_s2_q, col_bad;
  logic signed [2*DATA_W-1:0] mul_a, mul_b, prod;
  logic signed [ACC_W-1:0]   prod_ext, acc_q, acc_d;
  logic [1:0]                tail_q;

  assign col_bad  = col_rd >= COL_LIM;
  assign mul_a    = {{DATA_W{val_s2_q[DATA_W-1]}}, val_s2_q};
  assign mul_b    = {{DATA_W{x_rd[DATA_W-1]}}, x_rd};
  assign prod     = mul_a * mul_b;
  assign prod_ext = ACC_W'(prod);

  always_comb begin
    acc_d = acc_q;
    if (vld_pipe_q[2] && !bad_s2_q) acc_d = acc_q + prod_ext;
  end

  // ---------------- controller ----------------
  logic                    done_q, y_valid_q, err_q;
  logic signed [ACC_W-1:0] y_data_q;
  logic [ROW_W-1:0]        y_row_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      nrows_q    <= '0;
      ptr_ph_q   <= 1'b0;
      ptr_lo_q   <= '0;
      ptr_hi_q   <= '0;
      nz_q       <= '0;
      tail_q     <= '0;
      vld_pipe_q <= '0;
      val_s2_q   <= '0;
      bad_s2_q   <= 1'b0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      y_valid_q  <= 1'b0;
      y_data_q   <= '0;
      y_row_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      vld_pipe_q <= {vld_pipe_q[1], state_q == S_MAC};
      done_q     <= 1'b0;
      if (vld_pipe_q[1]) begin
        val_s2_q <= val_rd;
        bad_s2_q <= col_bad;
        if (col_bad) err_q <= 1'b1;
      end
      unique case (state_q)
        S_IDLE: if (start_i) begin
          row_q    <= '0;
          nrows_q  <= num_rows_i;
          ptr_ph_q <= 1'b0;
          busy_q   <= 1'b1;
          if (num_rows_i == '0) begin
            state_q <= S_FINISH;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_PTR_RD;
          end
        end
        // Two back-to-back reads on the single pointer read port: ptr[i], ptr[i+1].
        S_PTR_RD: begin
          ptr_ph_q <= ~ptr_ph_q;
          if (ptr_ph_q) begin
            ptr_lo_q <= ptr_rd;
            state_q  <= S_PTR_WAIT;
          end
        end
        S_PTR_WAIT: begin
          acc_q    <= '0;
          nz_q     <= ptr_lo_q;
          ptr_hi_q <= ptr_rd;
          tail_q   <= '0;
          if (ptr_rd < ptr_lo_q || ptr_rd > PTR_LIM || ptr_rd == ptr_lo_q) begin
            if (ptr_rd != ptr_lo_q) err_q <= 1'b1;
            state_q   <= S_EMIT;
            y_valid_q <= 1'b1;
            y_data_q  <= '0;
            y_row_q   <= row_q;
          end else begin
            state_q <= S_MAC;
          end
        end
        S_MAC: begin
          nz_q <= nz_q + DATA_W'(1);
          if (nz_q + DATA_W'(1) == ptr_hi_q) state_q <= S_MAC_TAIL;
        end
        S_MAC_TAIL: begin
          tail_q <= tail_q + 2'd1;
          if (tail_q == 2'(TAIL_CYC - 1)) begin
            state_q   <= S_EMIT;
            y_valid_q <= 1'b1;
            y_data_q  <= acc_d;
            y_row_q   <= row_q;
          end
        end
        S_EMIT: if (y_ready_i) begin
          y_valid_q <= 1'b0;
          if (row_q == nrows_q - ROW_W'(1)) begin
            state_q <= S_FINISH;
            done_q  <= 1'b1;
          end else begin
            row_q    <= row_q + ROW_W'(1);
            ptr_ph_q <= 1'b0;
            state_q  <= S_PTR_RD;
          end
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign y_valid_o = y_valid_q;
  assign y_data_o  = y_data_q;
  assign y_row_o   = y_row_q;
  assign err_o     = err_q;

endmodule
